// File: rtl/led_effect_sequencer_pkg.sv
// Shared types and constants for the LED bar effect sequencer.
// Holds the effect encodings, bar width, pattern constants and the per-position pattern lookup.
package led_effect_sequencer_pkg;

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_FILL   = 2'd1,
    MODE_BLINK  = 2'd2,
    MODE_ALT    = 2'd3
  } mode_e;

  localparam int NUM_MODES = 4;
  localparam int LED_W     = 7;

  localparam logic [LED_W-1:0] PAT_ALL   = 7'h7F;
  localparam logic [LED_W-1:0] PAT_ALT_A = 7'h55;
  localparam logic [LED_W-1:0] PAT_ALT_B = 7'h2A;

  // Pattern shown for a given effect at sequence position pos.
  function automatic logic [LED_W-1:0] effect_pattern(input mode_e m, input logic [2:0] pos);
    logic [3:0] fill_sh;
    fill_sh = {1'b0, pos} + 4'd1;
    case (m)
      MODE_BOUNCE: effect_pattern = 7'd1 << pos;
      MODE_FILL:   effect_pattern = (pos == 3'd7) ? 7'h00 : ~(PAT_ALL << fill_sh);
      MODE_BLINK:  effect_pattern = pos[0] ? 7'h00 : PAT_ALL;
      MODE_ALT:    effect_pattern = pos[0] ? PAT_ALT_B : PAT_ALT_A;
      default:     effect_pattern = 7'h00;
    endcase
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Programmable step-tick divider: limit = max(TICK_DIV >> speed_sel, 1).
// tick is the combinational fire condition; step is its registered one-cycle pulse.
module led_tick_gen #(
  parameter int unsigned TICK_DIV = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [1:0] speed_sel,
  output logic       tick,
  output logic       step
);

  logic [31:0] div_cnt_r;
  logic [31:0] shifted_s;
  logic [31:0] limit_m1_s;

  // Terminal count for the selected rate; >= lets a shortened limit fire at once.
  always_comb begin
    shifted_s = 32'(TICK_DIV) >> speed_sel;
    if (shifted_s == 32'd0) begin
      limit_m1_s = 32'd0;
    end else begin
      limit_m1_s = shifted_s - 32'd1;
    end
    tick = enable && (div_cnt_r >= limit_m1_s);
  end

  // Divider counter and registered step pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt_r <= 32'd0;
      step      <= 1'b0;
    end else if (!enable) begin
      div_cnt_r <= 32'd0;
      step      <= 1'b0;
    end else if (tick) begin
      div_cnt_r <= 32'd0;
      step      <= 1'b1;
    end else begin
      div_cnt_r <= div_cnt_r + 32'd1;
      step      <= 1'b0;
    end
  end

endmodule

// File: rtl/led_effect_sequencer.sv
// Sequences the 7-LED bar through bounce/fill/blink/alt effects on divided step ticks.
// Optional macro LED_DIM_EN adds a 16-level PWM gate on the bar (DIM_LEVEL on-counts).
module led_effect_sequencer
  import led_effect_sequencer_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 2500000,
  parameter int unsigned STEPS_PER_MODE = 28
`ifdef LED_DIM_EN
  ,
  parameter int unsigned DIM_LEVEL      = 8
`endif
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             next_req,
  input  logic [1:0]       speed_sel,
  output logic [LED_W-1:0] leds,
  output logic [1:0]       mode,
  output logic             step
);

  localparam int CNT_W = $clog2(STEPS_PER_MODE + 1);

  logic             tick_s;
  mode_e            mode_r;
  logic [2:0]       pos_r;
  logic             dir_r;
  logic [CNT_W-1:0] step_cnt_r;
  logic [LED_W-1:0] pattern_r;
  logic [2:0]       pos_nxt_s;
  logic             dir_nxt_s;
  logic             advance_s;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk       (clk_50M),
    .rst_n     (rst_n),
    .enable    (enable),
    .speed_sel (speed_sel),
    .tick      (tick_s),
    .step      (step)
  );

  // Position walk for the current effect; bounce reverses at both ends so endpoints show once.
  always_comb begin
    pos_nxt_s = 3'd0;
    dir_nxt_s = 1'b0;
    case (mode_r)
      MODE_BOUNCE: begin
        if (!dir_r) begin
          if (pos_r == 3'd6) begin
            pos_nxt_s = 3'd5;
            dir_nxt_s = 1'b1;
          end else begin
            pos_nxt_s = pos_r + 3'd1;
            dir_nxt_s = 1'b0;
          end
        end else begin
          if (pos_r == 3'd0) begin
            pos_nxt_s = 3'd1;
            dir_nxt_s = 1'b0;
          end else begin
            pos_nxt_s = pos_r - 3'd1;
            dir_nxt_s = 1'b1;
          end
        end
      end
      MODE_FILL:  pos_nxt_s = pos_r + 3'd1;
      MODE_BLINK: pos_nxt_s = {2'b00, ~pos_r[0]};
      MODE_ALT:   pos_nxt_s = {2'b00, ~pos_r[0]};
      default:    pos_nxt_s = 3'd0;
    endcase
    advance_s = next_req || (tick_s && (step_cnt_r == CNT_W'(STEPS_PER_MODE - 1)));
  end

  // Effect state: an advance discards any coincident pattern update.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      mode_r     <= MODE_BOUNCE;
      pos_r      <= 3'd0;
      dir_r      <= 1'b0;
      step_cnt_r <= '0;
      pattern_r  <= 7'h00;
    end else if (!enable) begin
      pos_r      <= 3'd0;
      dir_r      <= 1'b0;
      step_cnt_r <= '0;
      pattern_r  <= 7'h00;
    end else if (advance_s) begin
      mode_r     <= mode_e'(mode_r + 2'd1);
      pos_r      <= 3'd0;
      dir_r      <= 1'b0;
      step_cnt_r <= '0;
      pattern_r  <= 7'h00;
    end else if (tick_s) begin
      pattern_r  <= effect_pattern(mode_r, pos_r);
      pos_r      <= pos_nxt_s;
      dir_r      <= dir_nxt_s;
      step_cnt_r <= step_cnt_r + CNT_W'(1);
    end else begin
      pos_r      <= pos_r;
    end
  end

  assign mode = mode_r;

`ifdef LED_DIM_EN
  logic [3:0] pwm_cnt_r;
  logic       pwm_on_s;

  // Free-running PWM phase counter.
  always_ff @(posedge clk_50M) begin
    if (!rst_n) begin
      pwm_cnt_r <= 4'd0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + 4'd1;
    end
  end

  assign pwm_on_s = ({1'b0, pwm_cnt_r} < 5'(DIM_LEVEL));
  assign leds     = pattern_r & {LED_W{pwm_on_s}};
`else
  assign leds = pattern_r;
`endif

endmodule

// File: tb/tb_led_effect_sequencer.sv
// Randomized bench for led_effect_sequencer against a table-driven reference model.
module tb_led_effect_sequencer;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned STEPS    = 28;

  logic       clk_50M = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       next_req = 1'b0;
  logic [1:0] speed_sel = 2'd0;
  logic [6:0] leds;
  logic [1:0] mode;
  logic       step;

  always #10 clk_50M = ~clk_50M;

  led_effect_sequencer #(
    .TICK_DIV       (TICK_DIV),
    .STEPS_PER_MODE (STEPS)
  ) dut (
    .clk_50M   (clk_50M),
    .rst_n     (rst_n),
    .enable    (enable),
    .next_req  (next_req),
    .speed_sel (speed_sel),
    .leds      (leds),
    .mode      (mode),
    .step      (step)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: divider count, effect, patterns shown in this effect, outputs.
  int unsigned m_div = 0;
  int unsigned m_mode = 0;
  int unsigned m_shown = 0;
  logic [6:0]  m_leds = 7'h00;
  logic        m_step = 1'b0;

  logic [6:0] bounce_seq [12] = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20,
                                  7'h40, 7'h20, 7'h10, 7'h08, 7'h04, 7'h02};
  logic [6:0] fill_seq [8] = '{7'h01, 7'h03, 7'h07, 7'h0F, 7'h1F, 7'h3F, 7'h7F, 7'h00};
  logic [6:0] blink_seq [2] = '{7'h7F, 7'h00};
  logic [6:0] alt_seq [2] = '{7'h55, 7'h2A};

  function automatic logic [6:0] expected_pattern(input int unsigned md, input int unsigned n);
    case (md)
      0:       return bounce_seq[n % 12];
      1:       return fill_seq[n % 8];
      2:       return blink_seq[n % 2];
      default: return alt_seq[n % 2];
    endcase
  endfunction

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model across one rising edge using the currently driven inputs.
  task automatic model_edge();
    int unsigned lim;
    bit fire;
    if (!rst_n) begin
      m_div = 0; m_mode = 0; m_shown = 0; m_leds = 7'h00; m_step = 1'b0;
    end else if (!enable) begin
      m_div = 0; m_shown = 0; m_leds = 7'h00; m_step = 1'b0;
    end else begin
      lim = TICK_DIV >> speed_sel;
      if (lim == 0) lim = 1;
      fire = (m_div >= lim - 1);
      m_step = fire;
      m_div = fire ? 0 : m_div + 1;
      if (next_req || (fire && m_shown == STEPS - 1)) begin
        m_mode = (m_mode + 1) % 4;
        m_shown = 0;
        m_leds = 7'h00;
      end else if (fire) begin
        m_leds = expected_pattern(m_mode, m_shown);
        m_shown++;
      end
    end
  endtask

  task automatic cycle(input logic r, input logic e, input logic n, input logic [1:0] s);
    rst_n = r; enable = e; next_req = n; speed_sel = s;
    model_edge();
    @(negedge clk_50M);
    check_value("leds", {25'd0, leds}, {25'd0, m_leds});
    check_value("mode", {30'd0, mode}, m_mode);
    check_value("step", {31'd0, step}, {31'd0, m_step});
  endtask

  initial begin
    int first_step;
    logic en_hold;
    logic [1:0] spd_hold;

    repeat (3) cycle(1'b0, 1'b1, 1'b0, 2'd0);
    check_value("reset_leds", {25'd0, leds}, 32'h0);

    first_step = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 2'd0);
      if (step && first_step == 0) first_step = i;
    end
    check_value("first_step_latency", first_step, 32'd4);

    // Long enough for bounce plus auto-advance into fill.
    repeat (150) cycle(1'b1, 1'b1, 1'b0, 2'd0);
    check_value("auto_advanced_mode", {30'd0, mode}, 32'd1);

    cycle(1'b1, 1'b1, 1'b1, 2'd0);
    for (int i = 0; i < 8 && m_div != TICK_DIV - 1; i++) cycle(1'b1, 1'b1, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 1'b1, 2'd0);
    check_value("adv_on_step_mode", {30'd0, mode}, 32'd3);
    check_value("adv_on_step_leds", {25'd0, leds}, 32'h0);
    check_value("adv_on_step_pulse", {31'd0, step}, 32'd1);
    repeat (8) cycle(1'b1, 1'b1, 1'b0, 2'd0);
    cycle(1'b1, 1'b1, 1'b1, 2'd0);
    check_value("wrap_to_bounce", {30'd0, mode}, 32'd0);

    repeat (13) cycle(1'b1, 1'b1, 1'b0, 2'd0);
    repeat (4) cycle(1'b1, 1'b0, 1'b1, 2'd0);
    check_value("parked_mode", {30'd0, mode}, 32'd0);
    check_value("parked_leds", {25'd0, leds}, 32'h0);
    repeat (12) cycle(1'b1, 1'b1, 1'b0, 2'd0);

    for (int s = 1; s < 4; s++) repeat (10) cycle(1'b1, 1'b1, 1'b0, 2'(s));

    en_hold = 1'b1;
    spd_hold = 2'd0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 149) == 0) en_hold = ~en_hold;
      if ($urandom_range(0, 79) == 0) spd_hold = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 3)) : 2'd0;
      cycle(($urandom_range(0, 399) != 0), en_hold, ($urandom_range(0, 59) == 0), spd_hold);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
